// File: rtl/board_sw_sword_pkg.sv
// Shared definitions for the switch-chain reader and the serial display writer:
// scan FSM state encoding and the default shift-clock divider.
package board_sw_sword_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_t;

    localparam int unsigned DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/board_sw_sword_shift_tick_gen.sv
// Half-period tick generator: while run is high, tick pulses on every
// CLK_DIV-th cycle; dropping run restarts the count from zero.
module shift_tick_gen
    import board_sw_sword_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/board_sw_sword.sv
// Serial reader for a 74HC165-style switch chain with scan-to-scan debounce.
// Define BOARD_SW_SWORD_RAW_EN to add the undebounced raw/raw_stb outputs.
module board_sw_sword
    import board_sw_sword_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SCAN_GAP = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic             sw_clk,
    output logic             sw_pl_n,
    input  logic             sw_di,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             changed,
    output logic             busy
`ifdef BOARD_SW_SWORD_RAW_EN
    ,
    output logic [WIDTH-1:0] raw,
    output logic             raw_stb
`endif
);

    localparam int unsigned GW = $clog2(SCAN_GAP + 1);
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);

    sw_state_t        state, state_nxt;
    logic [GW-1:0]    gap_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] scan_reg;
    logic [WIDTH-1:0] last_scan;
    logic [DW-1:0]    stable_cnt, stable_nxt;
    logic             tick;
    logic             gap_expired;
    logic             bit_last;
    logic             sample;
    logic             accept;
    logic             sw_clk_nxt;

    shift_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .run  ((state == ST_LOAD) || (state == ST_SHIFT)),
        .tick (tick)
    );

    assign gap_expired = (gap_cnt == GW'(SCAN_GAP - 1));
    assign bit_last    = (bit_cnt == BW'(WIDTH - 1));
    assign sample      = (state == ST_SHIFT) && tick && !sw_clk;

    always_comb begin
        state_nxt  = state;
        sw_clk_nxt = 1'b0;
        stable_nxt = 1'b1;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE:  if (gap_expired && en) state_nxt = ST_LOAD;
            ST_LOAD:  if (tick) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                // sw_clk doubles as the half-period phase; the last low half ends the scan
                sw_clk_nxt = sw_clk;
                if (tick) begin
                    sw_clk_nxt = sw_clk ? 1'b0 : !bit_last;
                    if (!sw_clk && bit_last) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                if (scan_reg == last_scan) begin
                    stable_nxt = (stable_cnt == DW'(DEBOUNCE)) ? stable_cnt : stable_cnt + 1'b1;
                end
                accept = (stable_nxt == DW'(DEBOUNCE)) && (!valid || (scan_reg != data));
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            scan_reg   <= '0;
            last_scan  <= '0;
            stable_cnt <= '0;
            data       <= '0;
            valid      <= 1'b0;
            changed    <= 1'b0;
            sw_clk     <= 1'b0;
            sw_pl_n    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state   <= state_nxt;
            sw_clk  <= sw_clk_nxt;
            sw_pl_n <= (state_nxt != ST_LOAD);
            busy    <= (state_nxt != ST_IDLE);
            changed <= 1'b0;

            if (state == ST_DONE) begin
                gap_cnt <= '0;
            end else if (state == ST_IDLE && !gap_expired) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (state == ST_LOAD) begin
                bit_cnt <= '0;
            end else if (sample) begin
                bit_cnt  <= bit_cnt + 1'b1;
                scan_reg <= {scan_reg[WIDTH-2:0], sw_di};
            end

            if (state == ST_DONE) begin
                last_scan  <= scan_reg;
                stable_cnt <= stable_nxt;
                if (accept) begin
                    data    <= scan_reg;
                    valid   <= 1'b1;
                    changed <= valid;
                end
            end
        end
    end

`ifdef BOARD_SW_SWORD_RAW_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            raw     <= '0;
            raw_stb <= 1'b0;
        end else begin
            raw_stb <= (state == ST_DONE);
            if (state == ST_DONE) raw <= scan_reg;
        end
    end
`endif

endmodule
